// File: rtl/control_unit_pkg.sv
// rtl/control_unit_pkg.sv - opcode, class and keyword constants plus the ID control bundle
package control_unit_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_RSB = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_RSC = 4'b0111;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_TEQ = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_CMN = 4'b1011;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_BIC = 4'b1110;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [1:0] CLASS_DP = 2'b00;
  localparam logic [1:0] CLASS_LS = 2'b01;
  localparam logic [2:0] CLASS_BR = 3'b101;

  localparam logic [47:0] KW_NOP   = "NOP   ";
  localparam logic [47:0] KW_UNDEF = "UNDEF ";
  localparam logic [47:0] KW_B     = "B     ";
  localparam logic [47:0] KW_BL    = "BL    ";
  localparam logic [23:0] KW_LDR   = "LDR";
  localparam logic [23:0] KW_STR   = "STR";
  localparam logic [23:0] KW_SFX_S = "S  ";
  localparam logic [23:0] KW_SFX_B = "B  ";
  localparam logic [23:0] KW_PAD3  = "   ";

  typedef struct packed {
    logic [3:0] opcode;
    logic       am;
    logic       s_enable;
    logic       load_instr;
    logic       rf_enable;
    logic       size_enable;
    logic       rw_enable;
    logic       enable_signal;
    logic       bl_instr;
    logic       b_instr;
  } id_ctrl_t;

  // Compare-type ops update flags only and never write the register file.
  function automatic logic is_test_op(input logic [3:0] op);
    return (op[3:2] == 2'b10);
  endfunction

  function automatic logic [23:0] dp_mnemonic(input logic [3:0] op);
    logic [23:0] m;
    case (op)
      OP_AND:  m = "AND";
      OP_EOR:  m = "EOR";
      OP_SUB:  m = "SUB";
      OP_RSB:  m = "RSB";
      OP_ADD:  m = "ADD";
      OP_ADC:  m = "ADC";
      OP_SBC:  m = "SBC";
      OP_RSC:  m = "RSC";
      OP_TST:  m = "TST";
      OP_TEQ:  m = "TEQ";
      OP_CMP:  m = "CMP";
      OP_CMN:  m = "CMN";
      OP_ORR:  m = "ORR";
      OP_MOV:  m = "MOV";
      OP_BIC:  m = "BIC";
      default: m = "MVN";
    endcase
    return m;
  endfunction

endpackage

// File: rtl/control_unit_decode.sv
// rtl/control_unit_decode.sv - combinational ID decoder; keyword text built only with KEYWORD_EN
module control_unit_decode
  import control_unit_pkg::*;
(
  input  logic [31:0] i_instruction,
  output id_ctrl_t    o_ctrl,
  output logic [47:0] o_keyword
);

  logic w_is_nop;
  logic w_is_dp;
  logic w_is_ls;
  logic w_is_br;

  assign w_is_nop = (i_instruction == 32'h0);
  assign w_is_dp  = !w_is_nop && (i_instruction[27:26] == CLASS_DP);
  assign w_is_ls  = !w_is_nop && (i_instruction[27:26] == CLASS_LS);
  assign w_is_br  = !w_is_nop && (i_instruction[27:25] == CLASS_BR);

  always_comb begin
    o_ctrl = '0;
    if (w_is_dp) begin
      o_ctrl.opcode    = i_instruction[24:21];
      o_ctrl.am        = i_instruction[25];
      o_ctrl.s_enable  = i_instruction[20];
      o_ctrl.rf_enable = !is_test_op(i_instruction[24:21]);
    end else if (w_is_ls) begin
      o_ctrl.opcode        = i_instruction[23] ? OP_ADD : OP_SUB;
      o_ctrl.am            = i_instruction[25];
      o_ctrl.load_instr    = i_instruction[20];
      o_ctrl.rf_enable     = i_instruction[20];
      o_ctrl.rw_enable     = !i_instruction[20];
      o_ctrl.size_enable   = i_instruction[22];
      o_ctrl.enable_signal = 1'b1;
    end else if (w_is_br) begin
      o_ctrl.opcode    = OP_ADD;
      o_ctrl.b_instr   = 1'b1;
      o_ctrl.bl_instr  = i_instruction[24];
      o_ctrl.rf_enable = i_instruction[24];
    end
  end

`ifdef KEYWORD_EN
  always_comb begin
    o_keyword = KW_UNDEF;
    if (w_is_nop) begin
      o_keyword = KW_NOP;
    end else if (w_is_dp) begin
      o_keyword = {dp_mnemonic(i_instruction[24:21]),
                   (i_instruction[20] && !is_test_op(i_instruction[24:21])) ? KW_SFX_S : KW_PAD3};
    end else if (w_is_ls) begin
      o_keyword = {i_instruction[20] ? KW_LDR : KW_STR,
                   i_instruction[22] ? KW_SFX_B : KW_PAD3};
    end else if (w_is_br) begin
      o_keyword = i_instruction[24] ? KW_BL : KW_B;
    end
  end
`else
  assign o_keyword = 48'h0;
`endif

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - ID decode with bubble mux and EX/MEM control register; KEYWORD_EN enables keyword text
module control_unit
  import control_unit_pkg::*;
(
  input  logic        clk,
  input  logic        R,
  input  logic [31:0] instruction,
  input  logic        S,
  output logic [3:0]  id_opcode,
  output logic        id_AM,
  output logic        id_S_enable,
  output logic        id_load_instr,
  output logic        id_RF_enable,
  output logic        id_Size_enable,
  output logic        id_RW_enable,
  output logic        id_Enable_signal,
  output logic        id_BL_instr,
  output logic        id_B_instr,
  output logic [47:0] keyword,
  input  logic        ex_load_instr,
  input  logic        ex_RF_enable,
  input  logic        ex_Size_enable,
  input  logic        ex_RW_enable,
  input  logic        ex_Enable_signal,
  output logic        mem_load_instr,
  output logic        mem_RF_enable,
  output logic        mem_Size_enable,
  output logic        mem_RW_enable,
  output logic        mem_Enable_signal
);

  id_ctrl_t w_dec;
  id_ctrl_t w_id;

  control_unit_decode u_decode (
    .i_instruction (instruction),
    .o_ctrl        (w_dec),
    .o_keyword     (keyword)
  );

  // Bubble insertion kills the controls but leaves the keyword for tracing.
  assign w_id = S ? '0 : w_dec;

  assign id_opcode        = w_id.opcode;
  assign id_AM            = w_id.am;
  assign id_S_enable      = w_id.s_enable;
  assign id_load_instr    = w_id.load_instr;
  assign id_RF_enable     = w_id.rf_enable;
  assign id_Size_enable   = w_id.size_enable;
  assign id_RW_enable     = w_id.rw_enable;
  assign id_Enable_signal = w_id.enable_signal;
  assign id_BL_instr      = w_id.bl_instr;
  assign id_B_instr       = w_id.b_instr;

  logic r_mem_load_instr;
  logic r_mem_rf_enable;
  logic r_mem_size_enable;
  logic r_mem_rw_enable;
  logic r_mem_enable_signal;

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      r_mem_load_instr    <= 1'b0;
      r_mem_rf_enable     <= 1'b0;
      r_mem_size_enable   <= 1'b0;
      r_mem_rw_enable     <= 1'b0;
      r_mem_enable_signal <= 1'b0;
    end else begin
      r_mem_load_instr    <= ex_load_instr;
      r_mem_rf_enable     <= ex_RF_enable;
      r_mem_size_enable   <= ex_Size_enable;
      r_mem_rw_enable     <= ex_RW_enable;
      r_mem_enable_signal <= ex_Enable_signal;
    end
  end

  assign mem_load_instr    = r_mem_load_instr;
  assign mem_RF_enable     = r_mem_rf_enable;
  assign mem_Size_enable   = r_mem_size_enable;
  assign mem_RW_enable     = r_mem_rw_enable;
  assign mem_Enable_signal = r_mem_enable_signal;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench for control_unit against a mnemonic-level model
module tb_control_unit;

  logic        clk;
  logic        R;
  logic [31:0] instruction;
  logic        S;
  logic [3:0]  id_opcode;
  logic        id_AM, id_S_enable, id_load_instr, id_RF_enable, id_Size_enable;
  logic        id_RW_enable, id_Enable_signal, id_BL_instr, id_B_instr;
  logic [47:0] keyword;
  logic [4:0]  ex;
  logic        mem_load_instr, mem_RF_enable, mem_Size_enable, mem_RW_enable, mem_Enable_signal;

  int tests = 0;
  int fails = 0;

  control_unit dut (
    .clk              (clk),
    .R                (R),
    .instruction      (instruction),
    .S                (S),
    .id_opcode        (id_opcode),
    .id_AM            (id_AM),
    .id_S_enable      (id_S_enable),
    .id_load_instr    (id_load_instr),
    .id_RF_enable     (id_RF_enable),
    .id_Size_enable   (id_Size_enable),
    .id_RW_enable     (id_RW_enable),
    .id_Enable_signal (id_Enable_signal),
    .id_BL_instr      (id_BL_instr),
    .id_B_instr       (id_B_instr),
    .keyword          (keyword),
    .ex_load_instr    (ex[4]),
    .ex_RF_enable     (ex[3]),
    .ex_Size_enable   (ex[2]),
    .ex_RW_enable     (ex[1]),
    .ex_Enable_signal (ex[0]),
    .mem_load_instr   (mem_load_instr),
    .mem_RF_enable    (mem_RF_enable),
    .mem_Size_enable  (mem_Size_enable),
    .mem_RW_enable    (mem_RW_enable),
    .mem_Enable_signal(mem_Enable_signal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {opcode, AM, S_enable, load, RF, Size, RW, Enable, BL, B}
  logic [12:0] dut_id;
  logic [4:0]  dut_mem;
  assign dut_id  = {id_opcode, id_AM, id_S_enable, id_load_instr, id_RF_enable, id_Size_enable,
                    id_RW_enable, id_Enable_signal, id_BL_instr, id_B_instr};
  assign dut_mem = {mem_load_instr, mem_RF_enable, mem_Size_enable, mem_RW_enable, mem_Enable_signal};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [12:0] model_ctrl(input logic [31:0] ins, input logic s);
    logic [3:0] op;
    op = ins[24:21];
    if (s || ins == 32'h0) return 13'h0;
    if (ins[27:26] == 2'b00)
      return {op, ins[25], ins[20], 1'b0, (op < 4'd8 || op > 4'd11), 5'b0};
    if (ins[27:26] == 2'b01)
      return {(ins[23] ? 4'd4 : 4'd2), ins[25], 1'b0, ins[20], ins[20], ins[22], ~ins[20], 1'b1, 2'b00};
    if (ins[27:25] == 3'b101)
      return {4'd4, 3'b000, ins[24], 3'b000, ins[24], 1'b1};
    return 13'h0;
  endfunction

  function automatic logic [47:0] pad6(input string t);
    logic [47:0] k;
    for (int i = 0; i < 6; i++)
      k[47-8*i -: 8] = (i < t.len()) ? t[i] : 8'h20;
    return k;
  endfunction

  function automatic logic [47:0] model_kw(input logic [31:0] ins);
    string names[16] = '{"AND","EOR","SUB","RSB","ADD","ADC","SBC","RSC",
                         "TST","TEQ","CMP","CMN","ORR","MOV","BIC","MVN"};
    string t;
    int    op;
    op = int'(ins[24:21]);
    if (ins == 32'h0)                t = "NOP";
    else if (ins[27:26] == 2'b00)    t = (ins[20] && (op < 8 || op > 11)) ? {names[op], "S"} : names[op];
    else if (ins[27:26] == 2'b01)    t = {(ins[20] ? "LDR" : "STR"), (ins[22] ? "B" : "")};
    else if (ins[27:25] == 3'b101)   t = ins[24] ? "BL" : "B";
    else                             t = "UNDEF";
`ifdef KEYWORD_EN
    return pad6(t);
`else
    return (t.len() > 0) ? 48'h0 : 48'h0;
`endif
  endfunction

  function automatic logic [47:0] kw_lit(input logic [47:0] k);
`ifdef KEYWORD_EN
    return k;
`else
    return (k == k) ? 48'h0 : 48'h0;
`endif
  endfunction

  // Registered stage model: MEM holds whatever EX held at the last edge, cleared by reset.
  logic [4:0] m_mem;
  always @(posedge clk or negedge R)
    if (!R) m_mem <= 5'b0;
    else    m_mem <= ex;

  always @(negedge clk) begin
    check("id_model", 64'(dut_id), 64'(model_ctrl(instruction, S)));
    check("kw_model", 64'(keyword), 64'(model_kw(instruction)));
    check("mem_model", 64'(dut_mem), 64'(m_mem));
  end

  task automatic apply(input logic [31:0] ins, input logic s, input logic [4:0] e);
    @(posedge clk);
    #2;
    instruction = ins;
    S = s;
    ex = e;
    #1;
  endtask

  initial begin
    R = 1'b0;
    instruction = 32'h0;
    S = 1'b0;
    ex = 5'b11111;
    #1;
    check("reset_mem", 64'(dut_mem), 64'h0);
    #21;
    R = 1'b1;

    apply(32'hE292_1005, 1'b0, 5'b10101);
    check("adds_id", 64'(dut_id), 64'({4'b0100, 1'b1, 1'b1, 1'b0, 1'b1, 5'b00000}));
    check("adds_kw", 64'(keyword), 64'(kw_lit("ADDS  ")));
    apply(32'hE151_0002, 1'b0, 5'b01010);
    check("cmp_id", 64'(dut_id), 64'({4'b1010, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00000}));
    check("cmp_kw", 64'(keyword), 64'(kw_lit("CMP   ")));
    apply(32'hE5D4_3004, 1'b0, 5'b00000);
    check("ldrb_id", 64'(dut_id), 64'({4'b0100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00}));
    check("ldrb_kw", 64'(keyword), 64'(kw_lit("LDRB  ")));
    apply(32'hE584_3000, 1'b0, 5'b11111);
    check("str_id", 64'(dut_id), 64'({4'b0100, 4'b0000, 1'b0, 1'b1, 1'b1, 2'b00}));
    check("str_kw", 64'(keyword), 64'(kw_lit("STR   ")));
    apply(32'hEB00_0004, 1'b0, 5'b00110);
    check("bl_id", 64'(dut_id), 64'({4'b0100, 3'b000, 1'b1, 3'b000, 1'b1, 1'b1}));
    check("bl_kw", 64'(keyword), 64'(kw_lit("BL    ")));
    apply(32'hE292_1005, 1'b1, 5'b11000);
    check("bubble_id", 64'(dut_id), 64'h0);
    check("bubble_kw", 64'(keyword), 64'(kw_lit("ADDS  ")));
    apply(32'h0000_0000, 1'b0, 5'b00011);
    check("nop_id", 64'(dut_id), 64'h0);
    check("nop_kw", 64'(keyword), 64'(kw_lit("NOP   ")));
    apply(32'hEF00_0000, 1'b0, 5'b01100);
    check("undef_id", 64'(dut_id), 64'h0);
    check("undef_kw", 64'(keyword), 64'(kw_lit("UNDEF ")));

    apply(32'h0000_0001, 1'b0, 5'b10000);
    apply(32'hE110_0000, 1'b0, 5'b00001);
    apply(32'hE1B0_0001, 1'b0, 5'b00101);
    apply(32'hEA00_0010, 1'b0, 5'b11110);
    apply(32'hE8BD_0001, 1'b0, 5'b01111);
    apply(32'hE7C1_2003, 1'b0, 5'b10011);
    for (int op = 0; op < 16; op++)
      for (int s = 0; s < 2; s++)
        apply(32'hE000_0000 | (32'(op) << 21) | (32'(s) << 20) | ($urandom & 32'h020F_FFFF),
              1'(($urandom & 3) == 0), 5'($urandom));

    apply(32'hE292_1005, 1'b0, 5'b11111);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("mem_two_edges", 64'(dut_mem), 64'h1F);
    #2;
    R = 1'b0;
    #1;
    check("mem_async_clear", 64'(dut_mem), 64'h0);
    check("id_indep_of_R", 64'(dut_id), 64'({4'b0100, 1'b1, 1'b1, 1'b0, 1'b1, 5'b00000}));
    #2;
    R = 1'b1;
    #1;
    check("mem_hold_until_edge", 64'(dut_mem), 64'h0);
    @(posedge clk);
    #1;
    check("mem_reload", 64'(dut_mem), 64'h1F);

    #20;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 R  in  1  reset, asynchronous, active-low.
REQ-003 instruction  in  32  ID-stage instruction word.
REQ-004 S  in  1  bubble select; 1 forces all ID outputs to 0, 0 passes decode.
REQ-005 id_opcode out 4; id_AM, id_S_enable, id_load_instr, id_RF_enable, id_Size_enable, id_RW_enable, id_Enable_signal, id_BL_instr, id_B_instr out 1 each; all are muxed decode outputs.
REQ-006 keyword  out  48  6-char ASCII mnemonic, left-justified, space-padded.
REQ-007 ex_load_instr, ex_RF_enable, ex_Size_enable, ex_RW_enable, ex_Enable_signal  in  1 each  EX-stage controls.
REQ-008 mem_load_instr, mem_RF_enable, mem_Size_enable, mem_RW_enable, mem_Enable_signal  out  1 each  registered MEM-stage controls.

Function
REQ-009 Decode is purely combinational; a change on instruction or S reaches id_* and keyword in the same cycle.
REQ-010 instruction==0: NOP; all id_* 0; keyword "NOP   ".
REQ-011 Data processing, [27:26]=00: opcode=[24:21], AM=[25], S_enable=[20], RF_enable=1 except opcode 1000-1011 (TST/TEQ/CMP/CMN), which give RF_enable=0; other controls 0.
REQ-012 Data-processing keyword is the mnemonic from opcode (AND EOR SUB RSB ADD ADC SBC RSC TST TEQ CMP CMN ORR MOV BIC MVN), plus suffix "S" when [20]=1 and opcode is not 1000-1011.
REQ-013 Load/store, [27:26]=01: load_instr=[20], RF_enable=[20], RW_enable=~[20], Size_enable=[22], Enable_signal=1, AM=[25], opcode=0100 if [23]=1 else 0010, S_enable=0; keyword LDR/STR, with suffix "B" when [22]=1.
REQ-014 Branch, [27:25]=101: B_instr=1, BL_instr=[24], RF_enable=[24], opcode=0100, others 0; keyword "B     " or "BL    ".
REQ-015 Any other encoding: all id_* 0; keyword "UNDEF ".
REQ-016 S=1 zeroes every id_* output; keyword still reflects the decoded instruction.
REQ-017 Each mem_* output takes the corresponding ex_* input on every rising clk; the stage has no enable and no stall.

Reset
REQ-018 R=0 clears all mem_* outputs to 0 immediately, independent of clk.
REQ-019 After R deasserts, the first rising edge captures the ex_* inputs.
REQ-020 Decode outputs do not depend on R.

Configuration
REQ-021 KEYWORD_EN defined: the keyword generation logic is present.
REQ-022 KEYWORD_EN undefined: the keyword port remains and is tied to 48'h0; all other behaviour is identical.

Structure
REQ-023 Package control_unit_pkg holds: the opcode constants, the instruction-class field constants, the keyword string constants, and a packed struct bundling the ten ID control signals.
REQ-024 The combinational decoder is one sub-module, control_unit_decode. The S mux and the EX/MEM register stay in the top level.

Verification
REQ-025 0xE2921005 (ADDS), S=0 -> opcode 0100, AM 1, S_enable 1, RF_enable 1, all other controls 0, keyword "ADDS  ".
REQ-026 0xE1510002 (CMP), S=0 -> opcode 1010, S_enable 1, RF_enable 0, keyword "CMP   ".
REQ-027 0xE5D43004 (LDRB) -> load 1, RF 1, Size 1, RW 0, Enable 1, AM 0, opcode 0100, keyword "LDRB  ".
REQ-028 0xE5843000 (STR) -> RW 1, RF 0, Enable 1. 0xEB000004 (BL) -> B 1, BL 1, RF 1.
REQ-029 0xE2921005 with S=1 -> all id_* 0 and keyword "ADDS  ". Instruction 0 -> keyword "NOP   ".
REQ-030 ex_* = 1 for two edges gives mem_* = 1; then R=0 between edges -> mem_* = 0 at once; R=1 -> the next edge reloads.
